// File: rtl/interrupt_request_generator.sv
// interrupt_request_generator: latches peripheral events as pending requests
// and presents the lowest-index enabled request of each priority class on its
// own 32-bit interrupt word until the processor acknowledges it.
// Build option: define INT_EDGE_DETECT_EN for rising-edge event detection;
// when undefined, event lines are level-sensitive.
module interrupt_request_generator #(
    parameter int unsigned word_size     = 32,
    parameter int unsigned source_count  = 8,
    parameter logic [19:0] vector_base   = 20'h00100,
    parameter int unsigned vector_stride = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [source_count-1:0] event_in,
    input  logic [source_count-1:0] enable_mask,
    input  logic [source_count-1:0] priority_mask,
    input  logic                    interrupt_ack,
    output logic [word_size-1:0]    interrupt_1,
    output logic [word_size-1:0]    interrupt_2,
    output logic [source_count-1:0] pending,
    output logic                    overflow
);

    localparam int unsigned IDX_W = (source_count > 1) ? $clog2(source_count) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Channel 0 drives interrupt_1 (priority_mask = 1), channel 1 drives interrupt_2.
    state_e                  state_q [2];
    state_e                  state_d [2];
    logic [IDX_W-1:0]        idx_q   [2];
    logic [IDX_W-1:0]        idx_d   [2];
    logic [source_count-1:0] cand    [2];
    logic [1:0]              ack_ch;

    logic [source_count-1:0] pending_q, pending_d;
    logic                    overflow_q, overflow_d;
    logic [source_count-1:0] fire;
    logic [source_count-1:0] clear_mask;

    function automatic logic [IDX_W-1:0] lowest_index(input logic [source_count-1:0] v);
        lowest_index = '0;
        for (int unsigned i = source_count; i > 0; i--) begin
            if (v[i-1]) lowest_index = IDX_W'(i - 1);
        end
    endfunction

    function automatic logic [word_size-1:0] make_word(input logic [IDX_W-1:0] idx);
        logic [31:0] addr;
        addr = 32'(vector_base) + 32'(idx) * 32'(vector_stride);
        make_word = '0;
        make_word[word_size-1] = 1'b1;
        make_word[19:0] = addr[19:0];
    endfunction

`ifdef INT_EDGE_DETECT_EN
    logic [source_count-1:0] event_q, event_d;

    // Previous-cycle copy of the event lines for rising-edge detection.
    always_comb begin
        event_d = event_in;
        fire    = event_in & ~event_q & enable_mask;
    end

    // Event history register.
    always_ff @(posedge clock) begin
        if (reset) event_q <= '0;
        else       event_q <= event_d;
    end
`else
    // Level-sensitive: an enabled high line requests every cycle.
    always_comb begin
        fire = event_in & enable_mask;
    end
`endif

    // Selection candidates, ack routing (channel 1 first) and the clear mask.
    always_comb begin
        cand[0]    = pending_q & enable_mask & priority_mask;
        cand[1]    = pending_q & enable_mask & ~priority_mask;
        ack_ch     = '0;
        clear_mask = '0;
        if (interrupt_ack) begin
            if (state_q[0] == ASSERT)      ack_ch[0] = 1'b1;
            else if (state_q[1] == ASSERT) ack_ch[1] = 1'b1;
        end
        for (int unsigned c = 0; c < 2; c++) begin
            if (ack_ch[c]) clear_mask[idx_q[c]] = 1'b1;
        end
    end

    // Pending/overflow update; a new event wins over a same-cycle ack clear.
    always_comb begin
        pending_d  = (pending_q & ~clear_mask) | fire;
        overflow_d = overflow_q | (|(fire & pending_q & ~clear_mask));
    end

    // Per-channel next state: latch in IDLE, hold in ASSERT, one-cycle RELEASE.
    always_comb begin
        for (int unsigned c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            idx_d[c]   = idx_q[c];
            case (state_q[c])
                IDLE: begin
                    if (|cand[c]) begin
                        state_d[c] = ASSERT;
                        idx_d[c]   = lowest_index(cand[c]);
                    end
                end
                ASSERT:  if (ack_ch[c]) state_d[c] = RELEASE;
                RELEASE: state_d[c] = IDLE;
                default: state_d[c] = IDLE;
            endcase
        end
    end

    // State, index, pending and overflow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned c = 0; c < 2; c++) begin
                state_q[c] <= IDLE;
                idx_q[c]   <= '0;
            end
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                state_q[c] <= state_d[c];
                idx_q[c]   <= idx_d[c];
            end
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Interrupt words are valid only while the channel is in ASSERT.
    always_comb begin
        interrupt_1 = '0;
        interrupt_2 = '0;
        if (state_q[0] == ASSERT) interrupt_1 = make_word(idx_q[0]);
        if (state_q[1] == ASSERT) interrupt_2 = make_word(idx_q[1]);
        pending  = pending_q;
        overflow = overflow_q;
    end

endmodule

// File: doc/interrupt_request_generator.md
# interrupt_request_generator

Source end of the processor's two-word interrupt interface. Collects event lines from home-automation peripherals (sensors, timers, switch inputs) and latches each as a pending request. Presents the highest-priority enabled request on each of two 32-bit interrupt words for the processor's interrupt priority encoder. Holds each word until the processor acknowledges it, then clears that request and advances.

## Interface
- `word_size`, 32, width of each interrupt word
- `source_count`, 8, number of event inputs (2..16)
- `vector_base`, 20'h00100, vector address of source 0
- `vector_stride`, 16, address distance between consecutive source vectors

- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`
- `event_in`  in  source_count  peripheral event lines, synchronous to `clock`
- `enable_mask`  in  source_count  1 = source may set pending and be presented
- `priority_mask`  in  source_count  1 = source routed to channel 1 (high), 0 = channel 2 (low)
- `interrupt_ack`  in  1  one-cycle pulse from processor: presented request taken
- `interrupt_1`  out  word_size  high-priority interrupt word
- `interrupt_2`  out  word_size  low-priority interrupt word
- `pending`  out  source_count  registered pending bits
- `overflow`  out  1  sticky: an event arrived for an already-pending source

## Operation
- Word format: bit 31 = valid; bits 30:20 = 0; bits 19:0 = `vector_base + index*vector_stride`, truncated to 20 bits (wraps modulo 2^20). Both words are all-zero when not valid.
- Event detect: `event_in` is registered into `event_q`. A source fires when `event_in & ~event_q & enable_mask`.
- Firing sets `pending[i]`. If `pending[i]` is already 1, it stays set and `overflow` is set.
- Each channel has its own FSM with states IDLE, ASSERT and RELEASE.
  - IDLE: selects the lowest-index source with `pending & enable_mask` and a matching `priority_mask` bit. If one exists, it latches the index and moves to ASSERT.
  - ASSERT: drives the valid word from the latched index. There is no preemption: a lower index that becomes pending does not replace the presented one. Changes to `priority_mask` or `enable_mask` do not move or withdraw the held request.
  - RELEASE: drives zero for exactly one cycle, then returns to IDLE.
- Ack routing: `interrupt_ack` goes to channel 1 if channel 1 is in ASSERT, otherwise to channel 2 if it is in ASSERT, otherwise it is ignored. The acked channel clears `pending[latched index]` and moves to RELEASE.
- Simultaneous ack-clear and new event on the same source: set wins, so `pending` stays 1 and `overflow` does not change.
- Disabled sources never set `pending`. A source already pending when disabled keeps its bit but is not selected from IDLE.

## Timing
- Reset values: `interrupt_1` = 0, `interrupt_2` = 0, `pending` = 0, `overflow` = 0, `event_q` = 0, both FSMs in IDLE.
- Reset mid-ASSERT drops the word to 0 on the next cycle and discards all pending requests.
- Latency: event rises (sampled at edge k) → `pending` set after edge k → FSM to ASSERT and word valid after edge k+1. Event-to-word latency is 2 cycles.
- Ack sampled at edge a → word 0 after edge a, for one RELEASE cycle → IDLE after a+1 → next word valid after edge a+2 at the earliest.
- An event held high counts once. It must drop low for at least one cycle to re-fire.

## Configuration
- `INT_EDGE_DETECT_EN` defined: rising-edge detection as described above; `event_q` is present.
- `INT_EDGE_DETECT_EN` not defined: level-sensitive. `pending[i]` is set every cycle that `event_in[i] & enable_mask[i]`, and a source re-asserts after ack while its line stays high. `overflow` is set only when a level-high source is already pending at a cycle in which its ack-clear does not occur. `event_q` is removed.

## Test plan
- Reset, defaults, `enable_mask`=8'hFF, `priority_mask`=8'h00; pulse `event_in[3]` for 1 cycle → `interrupt_2`=32'h8000_0130 2 cycles later, `interrupt_1`=0; ack → `interrupt_2`=0 next cycle, `pending`=0.
- `priority_mask`=8'h01; events 0 and 5 fire in the same cycle → `interrupt_1`=32'h8000_0100 and `interrupt_2`=32'h8000_0150 together. First ack clears channel 1 only; second ack clears channel 2.
- Channel 2 asserting source 6; source 2 fires → `interrupt_2` stays 32'h8000_0160 until ack. After RELEASE, `interrupt_2`=32'h8000_0120.
- Source 4 pending, second rising edge on 4 → `overflow`=1 and stays 1 after ack; only reset clears it.
- `enable_mask[1]`=0, pulse `event_in[1]` → `pending`=0, both words stay 0. Reset asserted during ASSERT → all outputs 0 next cycle.
- `vector_base`=20'hFFFF0, `vector_stride`=16, source 2 fires → vector field 20'h00010 (wrap), word 32'h8000_0010.
